// File: rtl/somador_pkg.sv
// somador_pkg: shared state encoding and saturation limits for the digit-serial adder/subtractor
package somador_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction
endpackage

// File: rtl/somador_subtrator_serial_digito.sv
// somador_digito: combinational DIGIT-bit ripple adder slice
// x, y: digit operands; cin: carry in; sum: digit sum; cout: carry out of the top bit; cmsb: carry into the top bit
module somador_digito #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [DIGIT:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];
endmodule

// File: rtl/somador_subtrator_serial.sv
// somador_subtrator_serial: digit-serial two's-complement adder/subtractor with optional signed saturation
// in_valid/in_ready: operand handshake for a, b, sub, sat; out_valid/out_ready: result handshake for s, ov, cout
module somador_subtrator_serial
  import somador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             ov,
  output logic             cout
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
  if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_param_check
    $error("somador_subtrator_serial: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
  end
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, sat_q, sat_d, neg_q, neg_d, ov_q, ov_d, co_q, co_d;
  logic [DIGIT-1:0] dsum;
  logic dco, dcm, ovf;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0] res;
  somador_digito #(.DIGIT(DIGIT)) u_digito (
    .x   (a_q[DIGIT-1:0]),
    .y   (b_q[DIGIT-1:0]),
    .cin (c_q),
    .sum (dsum),
    .cout(dco),
    .cmsb(dcm)
  );
  // Operands shift down one digit per cycle; result digits enter at the top so
  // the first (LSB) digit lands at bit 0 after NDIG shifts.
  assign cat = {dsum, r_q};
  assign res = cat[WIDTH+DIGIT-1:DIGIT];
  assign ovf = dcm ^ dco;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    s_d = s_q;
    cnt_d = cnt_q;
    c_d = c_q;
    sat_d = sat_q;
    neg_d = neg_q;
    ov_d = ov_q;
    co_d = co_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) begin
        state_d = ST_RUN;
        a_d = a;
        b_d = b ^ {WIDTH{sub}};
        c_d = sub;
        sat_d = sat;
        neg_d = a[WIDTH-1];
        cnt_d = '0;
        r_d = '0;
      end
      ST_RUN: begin
        a_d = a_q >> DIGIT;
        b_d = b_q >> DIGIT;
        r_d = res;
        c_d = dco;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          ov_d = ovf;
          co_d = dco;
          // Overflow direction follows the sign of a: a negative a can only underflow.
          s_d = (sat_q && ovf) ? (neg_q ? SMIN : SMAX) : res;
        end
      end
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
      c_q <= 1'b0;
      sat_q <= 1'b0;
      neg_q <= 1'b0;
      ov_q <= 1'b0;
      co_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      c_q <= c_d;
      sat_q <= sat_d;
      neg_q <= neg_d;
      ov_q <= ov_d;
      co_q <= co_d;
    end
  end
  assign in_ready = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign s = s_q;
  assign ov = ov_q;
  assign cout = co_q;
endmodule
